// File: rtl/ili_reset_seq.sv
// ILI9341 RESX sequencer: guaranteed low pulse, then a recovery wait, with status and
// soft-trigger registers on a 4-word Avalon-MM slave.
module ili_reset_seq #(
  parameter int unsigned RST_LOW_CYCLES  = 500,
  parameter int unsigned RST_WAIT_CYCLES = 6000000,
  parameter int unsigned CNT_W           = 23
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rst_req_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        lcd_rst_n,
  output logic        ready,
  output logic        irq
);

  typedef enum logic [1:0] {
    StHold  = 2'd0,
    StPulse = 2'd1,
    StWait  = 2'd2,
    StReady = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LowLast  = CNT_W'(RST_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(RST_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_flag_q;
  logic             irq_en_q;
  logic [7:0]       seq_count_q;

  logic wr_en;
  logic soft_trig;
  logic flag_wr;
  logic seq_done;
  logic unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign soft_trig    = wr_en & (address == 2'd1) & writedata[0];
  assign flag_wr      = wr_en & (address == 2'd3);
  assign unused_wdata = ^writedata[31:2];

  // Completion only counts when neither the PIO nor a soft trigger pre-empts it.
  assign seq_done = rst_req_n & ~soft_trig & (state_q == StWait) & (cnt_q == WaitLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StPulse;
      cnt_q       <= '0;
      lcd_rst_n   <= 1'b0;
      ready       <= 1'b0;
      done_flag_q <= 1'b0;
      irq_en_q    <= 1'b0;
      seq_count_q <= 8'd0;
    end else begin
      if (!rst_req_n) begin
        state_q   <= StHold;
        cnt_q     <= '0;
        lcd_rst_n <= 1'b0;
        ready     <= 1'b0;
      end else if ((state_q == StHold) || soft_trig) begin
        // Every release or restart re-applies the full minimum low time.
        state_q   <= StPulse;
        cnt_q     <= '0;
        lcd_rst_n <= 1'b0;
        ready     <= 1'b0;
      end else begin
        case (state_q)
          StPulse: begin
            if (cnt_q == LowLast) begin
              state_q   <= StWait;
              cnt_q     <= '0;
              lcd_rst_n <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          StWait: begin
            if (cnt_q == WaitLast) begin
              state_q <= StReady;
              cnt_q   <= '0;
              ready   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          default: ;
        endcase
      end

      if (flag_wr) begin
        irq_en_q <= writedata[1];
      end

      if (seq_done) begin
        done_flag_q <= 1'b1;
        seq_count_q <= seq_count_q + 8'd1;
      end else if (flag_wr && writedata[0]) begin
        done_flag_q <= 1'b0;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {28'b0, state_q, lcd_rst_n, ready};
      2'd2:    readdata = {24'b0, seq_count_q};
      2'd3:    readdata = {30'b0, irq_en_q, done_flag_q};
      default: readdata = '0;
    endcase
  end

  assign irq = done_flag_q & irq_en_q;

endmodule

// File: tb/tb_ili_reset_seq.sv
// Scoreboard bench for ili_reset_seq: per-cycle {lcd_rst_n, ready, irq} and register reads
// are queued from the expected timing and compared as the DUT produces them.
module tb_ili_reset_seq;

  localparam int unsigned LOW   = 4;
  localparam int unsigned WAITC = 10;
  localparam int unsigned CW    = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rst_req_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        lcd_rst_n;
  logic        ready;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [2:0]  obs_q[$];
  logic [31:0] rd_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  ili_reset_seq #(
    .RST_LOW_CYCLES (LOW),
    .RST_WAIT_CYCLES(WAITC),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rst_req_n (rst_req_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .lcd_rst_n (lcd_rst_n),
    .ready     (ready),
    .irq       (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata;
  endtask

  // Expected waveform from a start edge: lows x low, WAITC x lcd high, then ready.
  function automatic void push_seq(input int lows, input logic irq_pre, input logic irq_post);
    for (int i = 0; i < lows; i++) obs_q.push_back({2'b00, irq_pre});
    for (int i = 0; i < int'(WAITC); i++) obs_q.push_back({2'b10, irq_pre});
    obs_q.push_back({2'b11, irq_post});
  endfunction

  task automatic test_reset();
    logic [2:0]  e;
    logic [31:0] v, ev;
    logic [31:0] exp_rd[4];
    reset_n   = 1'b0;
    rst_req_n = 1'b1;
    bus_idle();
    address   = 2'd0;
    repeat (3) tick();
    obs_q.push_back(3'b000);
    e = obs_q.pop_front();
    checks++;
    if ({lcd_rst_n, ready, irq} !== e) begin
      failures++;
      $display("FAIL reset_out got=%b exp=%b", {lcd_rst_n, ready, irq}, e);
    end
    exp_rd = '{32'd4, 32'd0, 32'd0, 32'd0};
    for (int a = 0; a < 4; a++) begin
      rd_q.push_back(exp_rd[a]);
      rd(2'(a), v);
      ev = rd_q.pop_front();
      checks++;
      if (v !== ev) begin
        failures++;
        $display("FAIL reset_rd addr=%0d got=%0h exp=%0h", a, v, ev);
      end
    end
    // The partial cycle between release and the first edge is the first low cycle.
    reset_n = 1'b1;
    push_seq(int'(LOW) - 1, 1'b0, 1'b0);
    for (int i = 0; i < int'(LOW + WAITC); i++) begin
      tick();
      e = obs_q.pop_front();
      checks++;
      if ({lcd_rst_n, ready, irq} !== e) begin
        failures++;
        $display("FAIL poweron cyc=%0d got=%b exp=%b", i, {lcd_rst_n, ready, irq}, e);
      end
    end
    exp_rd = '{32'd15, 32'd0, 32'd1, 32'd1};
    for (int a = 0; a < 4; a++) begin
      rd_q.push_back(exp_rd[a]);
      rd(2'(a), v);
      ev = rd_q.pop_front();
      checks++;
      if (v !== ev) begin
        failures++;
        $display("FAIL poweron_rd addr=%0d got=%0h exp=%0h", a, v, ev);
      end
    end
  endtask

  task automatic test_ignored_writes();
    logic [2:0]  e;
    logic [31:0] v, ev;
    logic [1:0]  wa[3];
    logic [31:0] wd[3];
    logic [31:0] exp_rd[4];
    wa = '{2'd0, 2'd2, 2'd1};
    wd = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFE};
    for (int i = 0; i < 3; i++) begin
      bus_wr(wa[i], wd[i]);
      obs_q.push_back(3'b110);
      tick();
      bus_idle();
      e = obs_q.pop_front();
      checks++;
      if ({lcd_rst_n, ready, irq} !== e) begin
        failures++;
        $display("FAIL ignored_wr idx=%0d got=%b exp=%b", i, {lcd_rst_n, ready, irq}, e);
      end
    end
    exp_rd = '{32'd15, 32'd0, 32'd1, 32'd1};
    for (int a = 0; a < 4; a++) begin
      rd_q.push_back(exp_rd[a]);
      rd(2'(a), v);
      ev = rd_q.pop_front();
      checks++;
      if (v !== ev) begin
        failures++;
        $display("FAIL ignored_rd addr=%0d got=%0h exp=%0h", a, v, ev);
      end
    end
  endtask

  task automatic test_short_pulse();
    logic [2:0]  e;
    logic [31:0] v, ev;
    rst_req_n = 1'b0;
    obs_q.push_back(3'b000);
    tick();
    e = obs_q.pop_front();
    checks++;
    if ({lcd_rst_n, ready, irq} !== e) begin
      failures++;
      $display("FAIL short_hold got=%b exp=%b", {lcd_rst_n, ready, irq}, e);
    end
    rd_q.push_back(32'd0);
    rd(2'd0, v);
    ev = rd_q.pop_front();
    checks++;
    if (v !== ev) begin
      failures++;
      $display("FAIL short_state got=%0h exp=%0h", v, ev);
    end
    rst_req_n = 1'b1;
    push_seq(int'(LOW), 1'b0, 1'b0);
    for (int i = 0; i < int'(LOW + WAITC + 1); i++) begin
      tick();
      e = obs_q.pop_front();
      checks++;
      if ({lcd_rst_n, ready, irq} !== e) begin
        failures++;
        $display("FAIL short_seq cyc=%0d got=%b exp=%b", i, {lcd_rst_n, ready, irq}, e);
      end
    end
    rd_q.push_back(32'd2);
    rd(2'd2, v);
    ev = rd_q.pop_front();
    checks++;
    if (v !== ev) begin
      failures++;
      $display("FAIL short_count got=%0h exp=%0h", v, ev);
    end
  endtask

  task automatic test_long_hold();
    logic [2:0]  e;
    logic [31:0] v, ev;
    rst_req_n = 1'b0;
    for (int i = 0; i < 50; i++) begin
      obs_q.push_back(3'b000);
      rd_q.push_back(32'd0);
      tick();
      e = obs_q.pop_front();
      checks++;
      if ({lcd_rst_n, ready, irq} !== e) begin
        failures++;
        $display("FAIL long_hold cyc=%0d got=%b exp=%b", i, {lcd_rst_n, ready, irq}, e);
      end
      rd(2'd0, v);
      ev = rd_q.pop_front();
      checks++;
      if (v !== ev) begin
        failures++;
        $display("FAIL long_state cyc=%0d got=%0h exp=%0h", i, v, ev);
      end
    end
    rst_req_n = 1'b1;
    push_seq(int'(LOW), 1'b0, 1'b0);
    for (int i = 0; i < int'(LOW + WAITC + 1); i++) begin
      tick();
      e = obs_q.pop_front();
      checks++;
      if ({lcd_rst_n, ready, irq} !== e) begin
        failures++;
        $display("FAIL long_seq cyc=%0d got=%b exp=%b", i, {lcd_rst_n, ready, irq}, e);
      end
    end
    rd_q.push_back(32'd3);
    rd(2'd2, v);
    ev = rd_q.pop_front();
    checks++;
    if (v !== ev) begin
      failures++;
      $display("FAIL long_count got=%0h exp=%0h", v, ev);
    end
  endtask

  task automatic test_soft_trigger();
    logic [2:0]  e;
    logic [31:0] v, ev;
    for (int i = 0; i < int'(LOW); i++) obs_q.push_back(3'b000);
    for (int i = 0; i < 6; i++) obs_q.push_back(3'b100);
    bus_wr(2'd1, 32'd1);
    for (int i = 0; i < int'(LOW) + 6; i++) begin
      tick();
      if (i == 0) bus_idle();
      e = obs_q.pop_front();
      checks++;
      if ({lcd_rst_n, ready, irq} !== e) begin
        failures++;
        $display("FAIL soft_first cyc=%0d got=%b exp=%b", i, {lcd_rst_n, ready, irq}, e);
      end
    end
    // Now in WAIT with cnt = 5: restart.
    bus_wr(2'd1, 32'd1);
    push_seq(int'(LOW), 1'b0, 1'b0);
    for (int i = 0; i < int'(LOW + WAITC + 1); i++) begin
      tick();
      if (i == 0) begin
        bus_idle();
        rd_q.push_back(32'd4);
        rd(2'd0, v);
        ev = rd_q.pop_front();
        checks++;
        if (v !== ev) begin
          failures++;
          $display("FAIL soft_state got=%0h exp=%0h", v, ev);
        end
      end
      e = obs_q.pop_front();
      checks++;
      if ({lcd_rst_n, ready, irq} !== e) begin
        failures++;
        $display("FAIL soft_seq cyc=%0d got=%b exp=%b", i, {lcd_rst_n, ready, irq}, e);
      end
    end
    rd_q.push_back(32'd4);
    rd(2'd2, v);
    ev = rd_q.pop_front();
    checks++;
    if (v !== ev) begin
      failures++;
      $display("FAIL soft_count got=%0h exp=%0h", v, ev);
    end
  endtask

  task automatic test_interrupt();
    logic [2:0]  e;
    logic [31:0] v, ev;
    logic [31:0] wd[2];
    logic [31:0] er[2];
    wd = '{32'd1, 32'd2};
    er = '{32'd0, 32'd2};
    for (int i = 0; i < 2; i++) begin
      bus_wr(2'd3, wd[i]);
      obs_q.push_back(3'b110);
      rd_q.push_back(er[i]);
      tick();
      bus_idle();
      e = obs_q.pop_front();
      checks++;
      if ({lcd_rst_n, ready, irq} !== e) begin
        failures++;
        $display("FAIL irq_setup idx=%0d got=%b exp=%b", i, {lcd_rst_n, ready, irq}, e);
      end
      rd(2'd3, v);
      ev = rd_q.pop_front();
      checks++;
      if (v !== ev) begin
        failures++;
        $display("FAIL irq_setup_rd idx=%0d got=%0h exp=%0h", i, v, ev);
      end
    end
    // Pass 0: plain completion. Pass 1: clear written on the completion edge; set wins.
    for (int pass = 0; pass < 2; pass++) begin
      bus_wr(2'd1, 32'd1);
      push_seq(int'(LOW), 1'b0, 1'b1);
      for (int i = 0; i < int'(LOW + WAITC + 1); i++) begin
        tick();
        if (i == 0) bus_idle();
        if (pass == 1 && i == int'(LOW + WAITC) - 1) bus_wr(2'd3, 32'd3);
        if (i == int'(LOW + WAITC)) bus_idle();
        e = obs_q.pop_front();
        checks++;
        if ({lcd_rst_n, ready, irq} !== e) begin
          failures++;
          $display("FAIL irq_seq pass=%0d cyc=%0d got=%b exp=%b", pass, i,
                   {lcd_rst_n, ready, irq}, e);
        end
      end
      rd_q.push_back(32'd3);
      rd(2'd3, v);
      ev = rd_q.pop_front();
      checks++;
      if (v !== ev) begin
        failures++;
        $display("FAIL irq_flags pass=%0d got=%0h exp=%0h", pass, v, ev);
      end
      bus_wr(2'd3, 32'd3);
      obs_q.push_back(3'b110);
      rd_q.push_back(32'd2);
      tick();
      bus_idle();
      e = obs_q.pop_front();
      checks++;
      if ({lcd_rst_n, ready, irq} !== e) begin
        failures++;
        $display("FAIL irq_clear pass=%0d got=%b exp=%b", pass, {lcd_rst_n, ready, irq}, e);
      end
      rd(2'd3, v);
      ev = rd_q.pop_front();
      checks++;
      if (v !== ev) begin
        failures++;
        $display("FAIL irq_clear_rd pass=%0d got=%0h exp=%0h", pass, v, ev);
      end
    end
    rd_q.push_back(32'd6);
    rd(2'd2, v);
    ev = rd_q.pop_front();
    checks++;
    if (v !== ev) begin
      failures++;
      $display("FAIL irq_count got=%0h exp=%0h", v, ev);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v, ev;
    int          k, el;
    for (int n = 0; n < 250; n++) begin
      bus_wr(2'd1, 32'd1);
      lat_q.push_back(int'(LOW + WAITC));
      tick();
      bus_idle();
      k = 0;
      while (ready !== 1'b1 && k < 40) begin
        tick();
        k++;
      end
      el = lat_q.pop_front();
      checks++;
      if (k != el) begin
        failures++;
        $display("FAIL wrap_latency seq=%0d got=%0d exp=%0d", n, k, el);
      end
      if (n == 248) begin
        rd_q.push_back(32'd255);
        rd(2'd2, v);
        ev = rd_q.pop_front();
        checks++;
        if (v !== ev) begin
          failures++;
          $display("FAIL wrap_255 got=%0h exp=%0h", v, ev);
        end
      end
    end
    rd_q.push_back(32'd0);
    rd(2'd2, v);
    ev = rd_q.pop_front();
    checks++;
    if (v !== ev) begin
      failures++;
      $display("FAIL wrap_zero got=%0h exp=%0h", v, ev);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0]  e;
    logic [31:0] v, ev;
    logic [31:0] exp_rd[4];
    // done_flag and irq_en are both set here, so irq stays high until reset.
    for (int i = 0; i < int'(LOW); i++) obs_q.push_back(3'b001);
    for (int i = 0; i < 2; i++) obs_q.push_back(3'b101);
    bus_wr(2'd1, 32'd1);
    for (int i = 0; i < int'(LOW) + 2; i++) begin
      tick();
      if (i == 0) bus_idle();
      e = obs_q.pop_front();
      checks++;
      if ({lcd_rst_n, ready, irq} !== e) begin
        failures++;
        $display("FAIL async_pre cyc=%0d got=%b exp=%b", i, {lcd_rst_n, ready, irq}, e);
      end
    end
    reset_n = 1'b0;
    obs_q.push_back(3'b000);
    #1;
    e = obs_q.pop_front();
    checks++;
    if ({lcd_rst_n, ready, irq} !== e) begin
      failures++;
      $display("FAIL async_out got=%b exp=%b", {lcd_rst_n, ready, irq}, e);
    end
    exp_rd = '{32'd4, 32'd0, 32'd0, 32'd0};
    for (int a = 0; a < 4; a++) begin
      rd_q.push_back(exp_rd[a]);
      rd(2'(a), v);
      ev = rd_q.pop_front();
      checks++;
      if (v !== ev) begin
        failures++;
        $display("FAIL async_rd addr=%0d got=%0h exp=%0h", a, v, ev);
      end
    end
    reset_n = 1'b1;
    push_seq(int'(LOW) - 1, 1'b0, 1'b0);
    for (int i = 0; i < int'(LOW + WAITC); i++) begin
      tick();
      e = obs_q.pop_front();
      checks++;
      if ({lcd_rst_n, ready, irq} !== e) begin
        failures++;
        $display("FAIL async_restart cyc=%0d got=%b exp=%b", i, {lcd_rst_n, ready, irq}, e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ignored_writes();
    test_short_pulse();
    test_long_hold();
    test_soft_trigger();
    test_interrupt();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ili_reset_seq.md
# ili_reset_seq

Timed reset sequencer for the ILI9341 2.4" TFT. It sits between the software-controlled reset PIO and the panel's RESX pin. It converts the PIO's active-low level request, or a register-triggered soft pulse, into a reset that always meets the panel's timing: a guaranteed minimum low time, then a 120 ms recovery wait. It reports "panel ready" through a 4-register Avalon-MM slave and an optional interrupt, so the TFT driver polls one bit instead of busy-waiting in software.

## Interface
Parameters:
- RST_LOW_CYCLES, 500, minimum RESX low time in clk cycles (10 µs at 50 MHz); must be ≥ 1
- RST_WAIT_CYCLES, 6000000, post-reset recovery time in clk cycles (120 ms at 50 MHz); must be ≥ 1
- CNT_W, 23, counter width; must hold max(RST_LOW_CYCLES, RST_WAIT_CYCLES) − 1

Ports:
- clk  in  1  system clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- rst_req_n  in  1  level request from the reset PIO (same clock domain); 0 = hold panel in reset
- address  in  2  Avalon-MM word address
- chipselect  in  1  Avalon-MM select
- write_n  in  1  Avalon-MM write strobe, active-low
- writedata  in  32  Avalon-MM write data
- readdata  out  32  Avalon-MM read data; zero-wait, combinational from address
- lcd_rst_n  out  1  registered drive to panel RESX
- ready  out  1  registered; 1 = recovery complete, panel may accept commands
- irq  out  1  done_flag & irq_en

## Operation
- States: HOLD, PULSE, WAIT, READY. There is one counter, cnt[CNT_W-1:0].
- Async reset: state = PULSE, cnt = 0, lcd_rst_n = 0, ready = 0, done_flag = 0, irq_en = 0, seq_count = 0. A power-on reset sequence therefore runs with no software action.
- Priority each cycle: rst_req_n == 0 beats a soft trigger, which beats a counter transition.
- Any state with rst_req_n == 0 → HOLD, cnt = 0, lcd_rst_n = 0, ready = 0.
- HOLD with rst_req_n == 1 → PULSE, cnt = 0. The full minimum low time is re-applied after every release, however short the PIO pulse was.
- PULSE: lcd_rst_n = 0. When cnt == RST_LOW_CYCLES−1 → WAIT, cnt = 0; otherwise cnt += 1.
- WAIT: lcd_rst_n = 1, ready = 0. When cnt == RST_WAIT_CYCLES−1 → READY, cnt = 0, done_flag = 1, seq_count += 1 (8-bit, wraps 255 → 0); otherwise cnt += 1.
- READY: lcd_rst_n = 1, ready = 1. The block stays here until a request arrives.
- Soft trigger: a write to address 1 with writedata[0] = 1 (and rst_req_n == 1), in any state except HOLD → PULSE, cnt = 0, ready = 0. This restarts a sequence that is already in progress. A write with writedata[0] = 0 has no effect.
- Register map (reads):
  - addr 0: {28'b0, state[1:0], lcd_rst_n, ready}, with HOLD=0, PULSE=1, WAIT=2, READY=3
  - addr 1: 0
  - addr 2: {24'b0, seq_count}
  - addr 3: {30'b0, irq_en, done_flag}
- Register map (writes):
  - addr 3: bit1 → irq_en; bit0 = 1 clears done_flag
- Simultaneous set and clear of done_flag: the set wins.
- Writes to addresses 0 and 2 are ignored.

## Timing
- All outputs are registered except readdata and irq. irq is a single AND of two registers.
- After rst_req_n returns to 1, lcd_rst_n stays 0 for exactly RST_LOW_CYCLES further cycles.
- From a soft trigger, lcd_rst_n is 0 for exactly RST_LOW_CYCLES cycles, starting the cycle after the write.
- From lcd_rst_n rising to ready rising: exactly RST_WAIT_CYCLES cycles.
- From deassertion of reset_n: lcd_rst_n is 0 for RST_LOW_CYCLES cycles, then 1 for RST_WAIT_CYCLES cycles, then ready = 1.
- rst_req_n falling: lcd_rst_n and ready go 0 on the next clock edge.
- An async reset mid-sequence restarts from the PULSE defaults immediately, without waiting for a clock edge.

## Test plan
Each scenario uses RST_LOW_CYCLES = 4 and RST_WAIT_CYCLES = 10.
- Power-on: release reset_n with rst_req_n = 1 → lcd_rst_n low for 4 cycles, high for 10, then ready = 1; addr 2 reads 1 and addr 3 reads 1.
- Short PIO pulse: rst_req_n = 0 for 1 cycle while in READY → ready drops next edge; lcd_rst_n stays low for 1 + 4 cycles; ready returns 10 cycles after lcd_rst_n rises; seq_count = 2.
- Long hold: rst_req_n = 0 for 50 cycles → state reads 0 and lcd_rst_n = 0 throughout; exactly 4 low cycles after release.
- Soft trigger mid-WAIT: write addr 1 = 1 at WAIT cnt = 5 → PULSE next cycle, cnt = 0, new 4-low/10-wait sequence; seq_count increments only once.
- Interrupt: write addr 3 = 2, then complete a sequence → irq = 1. Write addr 3 = 3 on the same cycle as completion → done_flag stays 1. Write addr 3 = 3 on a later cycle → irq = 0.
- Wrap and async reset: complete 256 sequences → addr 2 reads 0. Assert reset_n = 0 during WAIT → lcd_rst_n = 0 and ready = 0 without a clock edge.
